// File: rtl/bus_mux_pkg.sv
// Shared mode encoding for the arbitrating bus multiplexer.
package bus_mux_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_RR   = 2'd0;  // round-robin starting after the last winner
  localparam mode_t MODE_PRIO = 2'd1;  // fixed priority, lowest index wins
  localparam mode_t MODE_EXT  = 2'd2;  // source chosen by ext_sel

endpackage

// File: rtl/rr_pick.sv
// Wrapping first-set search: returns the first set bit of req at or after
// position start, wrapping from N_SRC-1 back to 0.
module rr_pick #(
  parameter int N_SRC = 8,
  parameter int SEL_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  localparam logic [SEL_W:0] N_LIM = (SEL_W + 1)'(N_SRC);

  // Scan every offset from start; the first requesting position wins.
  always_comb begin : p_search
    logic [SEL_W:0] pos;
    // NOTE: every output gets a value before the loop so no path leaves it unassigned (no latch).
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N_SRC; k++) begin
      pos = {1'b0, start} + (SEL_W + 1)'(k);
      if (pos >= N_LIM) pos = pos - N_LIM;
      if (!found && req[pos[SEL_W-1:0]]) begin
        found = 1'b1;
        idx   = pos[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arb_mux.sv
// N-source bus multiplexer: arbitrates among valid sources each cycle and
// registers the winning word onto a single output bus with valid/ready.
module bus_arb_mux
  import bus_mux_pkg::*;
#(
  parameter int    WIDTH = 32,
  parameter int    N_SRC = 8,
  parameter int    SEL_W = $clog2(N_SRC),
  parameter mode_t MODE  = MODE_RR
) (
  input  logic                   clock,
  input  logic                   clear_n,
  input  logic [N_SRC-1:0]       src_valid,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  output logic [N_SRC-1:0]       src_ready,
  input  logic [SEL_W-1:0]       ext_sel,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [SEL_W-1:0]       out_src,
  input  logic                   out_ready
);

  localparam logic [SEL_W:0]   N_LIM = (SEL_W + 1)'(N_SRC);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(N_SRC - 1);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_src_q,   out_src_d;
  logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

  logic [WIDTH-1:0] src_word [N_SRC];
  logic [SEL_W-1:0] pick_start, pick_idx, grant;
  logic             pick_found, grant_found;
  logic             load, xfer;

  for (genvar i = 0; i < N_SRC; i++) begin : g_word
    assign src_word[i] = src_data[i*WIDTH +: WIDTH];
  end

  // Fixed priority is the wrapping search anchored at source 0.
  assign pick_start = (MODE == MODE_RR) ? rr_ptr_q : '0;

  rr_pick #(
    .N_SRC (N_SRC),
    .SEL_W (SEL_W)
  ) u_pick (
    .req   (src_valid),
    .start (pick_start),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Grant selection: searched winner, or the externally named source if it is in range and valid.
  always_comb begin
    grant       = pick_idx;
    grant_found = pick_found;
    if (MODE == MODE_EXT) begin
      grant       = ext_sel;
      grant_found = ({1'b0, ext_sel} < N_LIM) && src_valid[ext_sel];
    end
  end

  // The register can take a new word when empty or being drained; reset blocks any accept.
  assign load = !out_valid_q || out_ready;
  assign xfer = load && grant_found && clear_n;

  // One-hot accept strobe to the source whose word is captured this cycle.
  always_comb begin
    src_ready = '0;
    if (xfer) src_ready[grant] = 1'b1;
  end

  // Next-state for the output register and the round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) out_valid_d = grant_found;
    if (xfer) begin
      out_data_d = src_word[grant];
      out_src_d  = grant;
      if (MODE == MODE_RR) rr_ptr_d = (grant == LAST) ? '0 : grant + SEL_W'(1);
    end
  end

  // State registers; clear_n discards any held word and restarts the rotation.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_bus_arb_mux.sv
// Scoreboard bench: three instances (round-robin N=4, priority N=4, external
// select N=5) share stimulus; a reference model predicts grants and pushes
// expected words, a monitor pops them when each DUT hands a word over.
module tb_bus_arb_mux;
  import bus_mux_pkg::*;

  logic        clock = 1'b0;
  logic        clear_n;
  logic [4:0]  src_valid;
  logic [79:0] src_data;
  logic [2:0]  ext_sel;
  logic        out_ready;

  logic [3:0]  sr_rr, sr_pr;
  logic [4:0]  sr_ex;
  logic        ov_rr, ov_pr, ov_ex;
  logic [15:0] od_rr, od_pr, od_ex;
  logic [1:0]  os_rr, os_pr;
  logic [2:0]  os_ex;

  logic [4:0]  sr [3];
  logic        ov [3];
  logic [15:0] od [3];
  logic [2:0]  os [3];

  assign sr[0] = {1'b0, sr_rr};
  assign sr[1] = {1'b0, sr_pr};
  assign sr[2] = sr_ex;
  assign ov[0] = ov_rr;
  assign ov[1] = ov_pr;
  assign ov[2] = ov_ex;
  assign od[0] = od_rr;
  assign od[1] = od_pr;
  assign od[2] = od_ex;
  assign os[0] = {1'b0, os_rr};
  assign os[1] = {1'b0, os_pr};
  assign os[2] = os_ex;

  always #5 clock = ~clock;

  bus_arb_mux #(.WIDTH(16), .N_SRC(4), .MODE(MODE_RR)) u_rr (
    .clock(clock), .clear_n(clear_n), .src_valid(src_valid[3:0]), .src_data(src_data[63:0]),
    .src_ready(sr_rr), .ext_sel(ext_sel[1:0]), .out_valid(ov_rr), .out_data(od_rr),
    .out_src(os_rr), .out_ready(out_ready));

  bus_arb_mux #(.WIDTH(16), .N_SRC(4), .MODE(MODE_PRIO)) u_pr (
    .clock(clock), .clear_n(clear_n), .src_valid(src_valid[3:0]), .src_data(src_data[63:0]),
    .src_ready(sr_pr), .ext_sel(ext_sel[1:0]), .out_valid(ov_pr), .out_data(od_pr),
    .out_src(os_pr), .out_ready(out_ready));

  bus_arb_mux #(.WIDTH(16), .N_SRC(5), .MODE(MODE_EXT)) u_ex (
    .clock(clock), .clear_n(clear_n), .src_valid(src_valid), .src_data(src_data),
    .src_ready(sr_ex), .ext_sel(ext_sel), .out_valid(ov_ex), .out_data(od_ex),
    .out_src(os_ex), .out_ready(out_ready));

  typedef struct {
    int          src;
    logic [15:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int checks = 0;
  int errors = 0;
  int m_valid [3];
  int m_rr    [3];
  int rst_events = 0;
  int rst_seen   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int n_of(input int m);
    return (m == 2) ? 5 : 4;
  endfunction

  // Winner chosen from the rules: rotation from rr, lowest index, or the named source.
  function automatic int pick(input int m, input logic [4:0] v, input int rr, input int ext);
    int n;
    n = n_of(m);
    if (m == 0) begin
      for (int k = 0; k < n; k++) if (v[(rr + k) % n]) return (rr + k) % n;
    end else if (m == 1) begin
      for (int i = 0; i < n; i++) if (v[i]) return i;
    end else begin
      if (ext < n && v[ext]) return ext;
    end
    return -1;
  endfunction

  function automatic logic [15:0] word(input int i);
    return src_data[i*16 +: 16];
  endfunction

  task automatic push(input int m, input exp_t e);
    case (m)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop(input int m, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '{src: 0, data: '0};
    case (m)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  always @(negedge clear_n) rst_events++;

  // Reference model: predicts accept strobes and occupancy, queues each accepted word.
  always @(negedge clock) begin
    #1;
    if (!clear_n || rst_events != rst_seen) begin
      rst_seen = rst_events;
      for (int m = 0; m < 3; m++) begin
        m_valid[m] = 0;
        m_rr[m]    = 0;
      end
      q0.delete();
      q1.delete();
      q2.delete();
    end
    for (int m = 0; m < 3; m++) begin
      if (!clear_n) begin
        check($sformatf("m%0d reset src_ready", m), sr[m], 0);
        check($sformatf("m%0d reset out_valid", m), ov[m], 0);
        check($sformatf("m%0d reset out_data", m), od[m], 0);
        check($sformatf("m%0d reset out_src", m), os[m], 0);
      end else begin
        bit   load;
        int   g;
        exp_t e;
        load = (m_valid[m] == 0) || out_ready;
        g    = pick(m, src_valid, m_rr[m], int'(ext_sel));
        check($sformatf("m%0d src_ready", m), sr[m], (load && g >= 0) ? (5'b1 << g) : 5'b0);
        check($sformatf("m%0d out_valid", m), ov[m], m_valid[m]);
        if (load) begin
          m_valid[m] = (g >= 0) ? 1 : 0;
          if (g >= 0) begin
            e.src  = g;
            e.data = word(g);
            push(m, e);
            if (m == 0) m_rr[m] = (g + 1) % n_of(m);
          end
        end
      end
    end
  end

  // Monitor: whenever a DUT hands a word to the consumer, compare it with the queue head.
  always @(negedge clock) begin
    for (int m = 0; m < 3; m++) begin
      if (clear_n && ov[m] && out_ready) begin
        exp_t e;
        bit   ok;
        pop(m, e, ok);
        if (!ok) check($sformatf("m%0d unexpected word", m), ov[m], 0);
        else begin
          check($sformatf("m%0d out_data", m), od[m], e.data);
          check($sformatf("m%0d out_src", m), os[m], e.src);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear_n   = 1'b0;
    src_valid = '1;
    out_ready = 1'b1;
    ext_sel   = '0;
    for (int i = 0; i < 5; i++) src_data[i*16 +: 16] = 16'hA0 + 16'(i);

    // Held in reset with every source requesting: nothing accepted, outputs cleared.
    repeat (3) cyc();
    check("rst sr_rr", sr_rr, 0);
    check("rst ov_rr", ov_rr, 0);
    check("rst od_rr", od_rr, 0);
    clear_n = 1'b1;

    // Round-robin rotation at full throughput.
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("rr rot src", os_rr, k % 4);
      check("rr rot data", od_rr, 16'hA0 + 16'(k % 4));
    end

    // Backpressure: the held word stays put and no source is accepted.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 check("stall sr_rr", sr_rr, 0);
      cyc();
      check("stall src", os_rr, 0);
      check("stall data", od_rr, 16'hA0);
      check("stall valid", ov_rr, 1);
    end
    out_ready = 1'b1;
    cyc();
    check("resume src", os_rr, 1);
    check("resume data", od_rr, 16'hA1);

    // Fixed priority.
    src_valid = 5'b01010;
    cyc();
    cyc();
    check("prio src1 a", os_pr, 1);
    cyc();
    check("prio src1 b", os_pr, 1);
    src_valid = 5'b01000;
    cyc();
    check("prio src3", os_pr, 3);

    // External select, in range then out of range.
    ext_sel   = 3'd2;
    src_valid = 5'b00100;
    #1 check("ext sr sel2", sr_ex, 5'b00100);
    cyc();
    check("ext src2", os_ex, 2);
    check("ext valid", ov_ex, 1);
    ext_sel   = 3'd5;
    src_valid = '1;
    #1 check("ext sr sel5", sr_ex, 0);
    cyc();
    check("ext drop valid", ov_ex, 0);

    // Asynchronous reset pulse between clock edges.
    cyc();
    check("pre-pulse ov_rr", ov_rr, 1);
    clear_n = 1'b0;
    #1;
    check("pulse ov_rr", ov_rr, 0);
    check("pulse ov_pr", ov_pr, 0);
    check("pulse od_rr", od_rr, 0);
    check("pulse sr_rr", sr_rr, 0);
    clear_n = 1'b1;
    cyc();
    check("post-pulse rr src", os_rr, 0);
    check("post-pulse rr data", od_rr, 16'hA0);

    // Randomised traffic with occasional mid-cycle resets.
    repeat (800) begin
      cyc();
      src_valid = 5'($urandom);
      for (int i = 0; i < 5; i++) src_data[i*16 +: 16] = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      ext_sel   = 3'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        #1 clear_n = 1'b0;
        #1 clear_n = 1'b1;
      end
    end
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
